// File: rtl/gcd_stream_if.sv
// Operand/result handshake bundle for gcd_stream_unit.
// The master side feeds operands and consumes results; the slave side is the engine.
interface gcd_stream_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic [CNT_W-1:0] out_iters;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, out_err, out_iters
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, out_err, out_iters
    );
endinterface

// File: rtl/gcd_stream_unit.sv
// Handshaked iterative GCD engine: IDLE -> CALC -> DONE -> IDLE, with a saturating step counter.
// Define GCD_STEIN_EN to use the binary (Stein) step instead of the default subtractive step.
module gcd_stream_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    gcd_stream_if.slave  bus
);
    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [CNT_W-1:0] r_iters;
    logic [WIDTH-1:0] r_gcd;
    logic             r_err;
    logic [CNT_W-1:0] r_iters_out;

    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_term;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_a_zero = (r_a == '0);
    assign w_b_zero = (r_b == '0);
    assign w_term   = w_a_zero || w_b_zero || (r_a == r_b);

    always_comb begin
        if (w_a_zero && w_b_zero) begin
            w_result = '0;
        end else if (w_a_zero) begin
            w_result = r_b;
        end else if (w_b_zero) begin
            w_result = r_a;
        end else begin
            w_result = r_a << r_k;
        end
    end

    // One reduction step; only meaningful while neither terminal condition holds.
    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        w_k_nxt = r_k;
`ifdef GCD_STEIN_EN
        if (!r_a[0] && !r_b[0]) begin
            w_a_nxt = r_a >> 1;
            w_b_nxt = r_b >> 1;
            w_k_nxt = r_k + KW'(1);
        end else if (!r_a[0]) begin
            w_a_nxt = r_a >> 1;
        end else if (!r_b[0]) begin
            w_b_nxt = r_b >> 1;
        end else if (r_a > r_b) begin
            w_a_nxt = r_a - r_b;
        end else begin
            w_b_nxt = r_b - r_a;
        end
`else
        if (r_a > r_b) begin
            w_a_nxt = r_a - r_b;
        end else begin
            w_b_nxt = r_b - r_a;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next_state = S_CALC;
            S_CALC:  if (w_term) w_next_state = S_DONE;
            S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers change only on the CALC->DONE edge so they stay stable through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            r_iters     <= '0;
            r_gcd       <= '0;
            r_err       <= 1'b0;
            r_iters_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_k     <= '0;
                        r_iters <= '0;
                    end
                end
                S_CALC: begin
                    if (w_term) begin
                        r_gcd       <= w_result;
                        r_err       <= w_a_zero && w_b_zero;
                        r_iters_out <= r_iters;
                    end else begin
                        r_a <= w_a_nxt;
                        r_b <= w_b_nxt;
                        r_k <= w_k_nxt;
                        if (r_iters != {CNT_W{1'b1}}) begin
                            r_iters <= r_iters + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_gcd   = r_gcd;
    assign bus.out_err   = r_err;
    assign bus.out_iters = r_iters_out;
endmodule

// File: tb/tb_gcd_stream_unit.sv
// Randomized self-checking bench for gcd_stream_unit (32-bit default and 8-bit/4-bit-counter instances).
// Expected results come from Euclid's algorithm (subtractive build) or the binary-GCD rules (GCD_STEIN_EN).
module tb_gcd_stream_unit;
    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_stream_if #(.WIDTH(32), .CNT_W(16)) if32 ();
    gcd_stream_if #(.WIDTH(8),  .CNT_W(4))  if8  ();

    gcd_stream_unit #(.WIDTH(32), .CNT_W(16)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    gcd_stream_unit #(.WIDTH(8),  .CNT_W(4))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    logic        tb_in_valid = 1'b0;
    logic        tb_out_ready = 1'b0;
    logic [31:0] tb_in_a = '0;
    logic [31:0] tb_in_b = '0;
    logic        sel8 = 1'b0;

    assign if32.in_valid  = tb_in_valid & ~sel8;
    assign if8.in_valid   = tb_in_valid & sel8;
    assign if32.in_a      = tb_in_a;
    assign if32.in_b      = tb_in_b;
    assign if8.in_a       = tb_in_a[7:0];
    assign if8.in_b       = tb_in_b[7:0];
    assign if32.out_ready = tb_out_ready;
    assign if8.out_ready  = tb_out_ready;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_gcd;
    logic        w_err;
    logic [31:0] w_iters;

    assign w_in_ready  = sel8 ? if8.in_ready  : if32.in_ready;
    assign w_out_valid = sel8 ? if8.out_valid : if32.out_valid;
    assign w_gcd       = sel8 ? {24'd0, if8.out_gcd} : if32.out_gcd;
    assign w_err       = sel8 ? if8.out_err   : if32.out_err;
    assign w_iters     = sel8 ? {28'd0, if8.out_iters} : {16'd0, if32.out_iters};

    int errors = 0;
    int checks = 0;
    longint unsigned last_gcd;
    longint unsigned last_iters;

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: gcd, error flag, and number of step cycles (unsaturated).
    function automatic void ref_gcd(input longint unsigned a_in, input longint unsigned b_in,
                                    output longint unsigned g, output bit err, output longint unsigned steps);
        longint unsigned a = a_in;
        longint unsigned b = b_in;
        err   = (a == 0) && (b == 0);
        steps = 0;
        g     = 0;
        if (a == 0 || b == 0) begin
            g = a + b;
            return;
        end
`ifdef GCD_STEIN_EN
        begin
            int k = 0;
            while (a != b) begin
                if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; k++; end
                else if (a % 2 == 0) a = a / 2;
                else if (b % 2 == 0) b = b / 2;
                else if (a > b) a = a - b;
                else b = b - a;
                steps++;
            end
            g = a * (64'd1 << k);
        end
`else
        // Subtractive steps equal the sum of Euclid quotients minus the final a==b stop.
        begin
            longint unsigned x = a;
            longint unsigned y = b;
            longint unsigned qsum = 0;
            while (y != 0) begin
                longint unsigned r = x % y;
                qsum += x / y;
                x = y;
                y = r;
            end
            g = x;
            steps = qsum - 1;
        end
`endif
    endfunction

    task automatic run_pair(input string tag, input longint unsigned a, input longint unsigned b, input int hold);
        longint unsigned eg, steps, eit, sat;
        bit ee;
        int n;
        ref_gcd(a, b, eg, ee, steps);
        sat = sel8 ? 15 : 65535;
        eit = (steps > sat) ? sat : steps;
        n = 0;
        while (!w_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check_val({tag, "_rdy"}, w_in_ready, 1);
        tb_in_a = a[31:0];
        tb_in_b = b[31:0];
        tb_in_valid = 1'b1;
        tb_out_ready = 1'b0;
        @(posedge clk); #1;
        n = 0;
        // Operand traffic during CALC must be ignored.
        while (!w_out_valid && n < LIMIT) begin
            tb_in_valid = 1'($urandom_range(0, 1));
            tb_in_a = $urandom;
            tb_in_b = $urandom;
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_lat"}, n, steps + 1);
        check_val({tag, "_gcd"}, w_gcd, eg);
        check_val({tag, "_err"}, w_err, ee);
        check_val({tag, "_iters"}, w_iters, eit);
        last_gcd = w_gcd;
        last_iters = w_iters;
        for (int i = 0; i < hold; i++) begin
            tb_in_valid = 1'($urandom_range(0, 1));
            tb_in_a = $urandom;
            tb_in_b = $urandom;
            @(posedge clk); #1;
            check_val({tag, "_hold_v"}, w_out_valid, 1);
            check_val({tag, "_hold_g"}, w_gcd, eg);
            check_val({tag, "_hold_rdy"}, w_in_ready, 0);
        end
        // The exit edge must not also accept the pair presented alongside it.
        tb_out_ready = 1'b1;
        tb_in_valid = 1'b1;
        tb_in_a = 32'd5;
        tb_in_b = 32'd5;
        @(posedge clk); #1;
        check_val({tag, "_exit_v"}, w_out_valid, 0);
        check_val({tag, "_bubble"}, w_in_ready, 1);
        tb_in_valid = 1'b0;
        tb_out_ready = 1'b0;
    endtask

    initial begin
        longint unsigned ra, rb;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rdy32", if32.in_ready, 1);
        check_val("rst_vld32", if32.out_valid, 0);
        check_val("rst_gcd32", if32.out_gcd, 0);
        check_val("rst_rdy8", if8.in_ready, 1);
        check_val("rst_it8", if8.out_iters, 0);
        @(negedge clk);
        rst = 1'b0;

        sel8 = 1'b0;
        run_pair("p48_18", 48, 18, 10);
        check_val("p48_18_const", last_gcd, 6);
`ifdef GCD_STEIN_EN
        check_val("p48_18_it_const", last_iters, 6);
`else
        check_val("p48_18_it_const", last_iters, 4);
`endif
        run_pair("p17_5", 17, 5, 0);
        check_val("p17_5_const", last_gcd, 1);
        run_pair("p0_0", 0, 0, 2);
        run_pair("p0_9", 0, 9, 0);
        check_val("p0_9_const", last_gcd, 9);
        run_pair("p12_0", 12, 0, 1);
        run_pair("p7_7", 7, 7, 0);
        run_pair("pbig", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0);

        // Reset while a long calculation is in flight.
        run_pair("pre_rst", 100, 75, 0);
        tb_in_a = 32'd1000;
        tb_in_b = 32'd1;
        tb_in_valid = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("mid_rst_rdy", if32.in_ready, 1);
        check_val("mid_rst_vld", if32.out_valid, 0);
        check_val("mid_rst_gcd", if32.out_gcd, 0);
        check_val("mid_rst_err", if32.out_err, 0);
        check_val("mid_rst_it", if32.out_iters, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("post_rst_vld", if32.out_valid, 0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom_range(0, 1023);
            rb = $urandom_range(0, 1023);
            if ($urandom_range(0, 7) == 0) ra = 0;
            if ($urandom_range(0, 7) == 0) rb = 0;
            run_pair($sformatf("r32_%0d", i), ra, rb, $urandom_range(0, 3));
        end

        sel8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_pair("p255_1", 255, 1, 0);
`ifndef GCD_STEIN_EN
        check_val("p255_1_sat", last_iters, 15);
`endif
        check_val("p255_1_g", last_gcd, 1);
        run_pair("p8_48_18", 48, 18, 0);
        for (int i = 0; i < 20; i++) begin
            run_pair($sformatf("r8_%0d", i), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
